mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 64, address width of both requesters and the memory port.
REQ-002 Parameter: DATA_W, 64, data width; strobe width is DATA_W/8.
REQ-003 Parameter: STARVE_MAX, 4, consecutive D grants allowed while I waits (range 1..15).
REQ-004 Ports, one per line:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  fetch read request.
- i_addr  in  ADDR_W  fetch address.
- i_addr_ok  out  1  port accepted fetch address.
- i_data_ok  out  1  fetch data valid.
- i_rdata  out  DATA_W  fetch read data.
- d_valid  in  1  memory-stage request.
- d_addr  in  ADDR_W  memory-stage address.
- d_size  in  3  access size code (msize encoding).
- d_strobe  in  DATA_W/8  byte write enables; all zero means load.
- d_wdata  in  DATA_W  store data, lane-aligned.
- d_addr_ok  out  1  port accepted memory-stage address.
- d_data_ok  out  1  memory-stage transaction complete.
- d_rdata  out  DATA_W  load data.
- m_valid  out  1  shared port request.
- m_addr  out  ADDR_W  shared port address.
- m_size  out  3  shared port size.
- m_strobe  out  DATA_W/8  shared port strobe.
- m_wdata  out  DATA_W  shared port write data.
- m_addr_ok  in  1  port address handshake.
- m_data_ok  in  1  port completion handshake.
- m_rdata  in  DATA_W  port read data.
- grant_i  out  1  status: I owns port.
- grant_d  out  1  status: D owns port.

Function
REQ-005 FSM states IDLE, GRANT_I, GRANT_D; state and grant are registered.
REQ-006 In IDLE with only d_valid: next state GRANT_D; with only i_valid: GRANT_I; with neither: stay IDLE.
REQ-007 In IDLE with both valid: GRANT_D unless starve counter equals STARVE_MAX, then GRANT_I.
REQ-008 Starve counter (4 bits): increments on each IDLE->GRANT_D transition taken while i_valid=1; clears on any IDLE->GRANT_I transition; saturates at STARVE_MAX.
REQ-009 In GRANT_x, m_valid/m_addr/m_size/m_strobe/m_wdata combinationally mirror the owner's inputs; I requests drive m_size=3'b011 (8 bytes), m_strobe=0, m_wdata=0.
REQ-010 In IDLE, m_valid=0 and all m_* outputs are 0.
REQ-011 m_addr_ok, m_data_ok, m_rdata route only to the owner's *_addr_ok/*_data_ok/*_rdata; non-owner sees 0s.
REQ-012 GRANT_x -> IDLE on the cycle after m_data_ok=1; one IDLE cycle separates consecutive transactions.
REQ-013 Latency: request raised at cycle t in IDLE -> m_valid=1 at t+1; best-case completion at t+1 if m_data_ok returns same cycle.
REQ-014 Owner must hold valid and payload stable until its data_ok; deassertion while granted is a protocol error, flagged by simulation assertion; FSM still waits for m_data_ok.
REQ-015 m_data_ok while in IDLE is ignored and not forwarded.
REQ-016 grant_i=1 exactly in GRANT_I, grant_d=1 exactly in GRANT_D; never both.

Reset
REQ-017 reset=0 forces IDLE, starve counter 0, all outputs 0, immediately and independent of clk.
REQ-018 Reset mid-transaction abandons it; no *_data_ok is produced for it after release.
REQ-019 First grant decision occurs on the first rising clk edge after reset returns high.

Verification
REQ-020 Only i_valid, addr 0x8000_0000, m_data_ok at 2nd granted cycle, m_rdata 0x1234 -> m_valid one cycle after request, i_data_ok=1, i_rdata=0x1234, d_data_ok=0, then IDLE.
REQ-021 Both valid same cycle, counter 0 -> GRANT_D; d_strobe 0xF0, d_wdata 0xAABBCCDD_00000000 appear on m_strobe/m_wdata.
REQ-022 Both held valid continuously with STARVE_MAX=4 -> grant order D,D,D,D,I, counter returns to 0.
REQ-023 Reset asserted during GRANT_D before m_data_ok -> m_valid=0, grant_d=0 at once; after release no d_data_ok.
REQ-024 m_data_ok pulsed in IDLE -> i_data_ok=d_data_ok=0, state unchanged.
REQ-025 Back-to-back I requests -> exactly one IDLE cycle with m_valid=0 between completions.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (fetch / memory-stage) arbiter onto one shared memory port
// Memory-stage wins ties until the fetch side has been passed over STARVE_MAX times in a row.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_addr_ok,
    output logic                i_data_ok,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_valid,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [2:0]          d_size,
    input  logic [DATA_W/8-1:0] d_strobe,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [2:0]          m_size,
    output logic [DATA_W/8-1:0] m_strobe,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                grant_i,
    output logic                grant_d
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Counter only moves on IDLE exits; it never exceeds the limit because reaching it forces an I grant.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        case (state)
            IDLE: begin
                if (d_valid && i_valid) begin
                    if (starve_cnt == STARVE_LIM) begin
                        state_nxt  = GRANT_I;
                        starve_nxt = 4'd0;
                    end else begin
                        state_nxt  = GRANT_D;
                        starve_nxt = (starve_cnt >= STARVE_LIM) ? STARVE_LIM : starve_cnt + 4'd1;
                    end
                end else if (d_valid) begin
                    state_nxt = GRANT_D;
                end else if (i_valid) begin
                    state_nxt  = GRANT_I;
                    starve_nxt = 4'd0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (m_data_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign grant_i = (state == GRANT_I);
    assign grant_d = (state == GRANT_D);

    always_comb begin
        m_valid   = 1'b0;
        m_addr    = '0;
        m_size    = 3'b000;
        m_strobe  = '0;
        m_wdata   = '0;
        i_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        i_rdata   = '0;
        d_addr_ok = 1'b0;
        d_data_ok = 1'b0;
        d_rdata   = '0;
        if (grant_i) begin
            // Fetches are always full-width reads.
            m_valid   = i_valid;
            m_addr    = i_addr;
            m_size    = 3'b011;
            i_addr_ok = m_addr_ok;
            i_data_ok = m_data_ok;
            i_rdata   = m_rdata;
        end else if (grant_d) begin
            m_valid   = d_valid;
            m_addr    = d_addr;
            m_size    = d_size;
            m_strobe  = d_strobe;
            m_wdata   = d_wdata;
            d_addr_ok = m_addr_ok;
            d_data_ok = m_data_ok;
            d_rdata   = m_rdata;
        end
    end

`ifndef SYNTHESIS
    i_holds_valid: assert property (@(posedge clk) disable iff (!reset)
        (state == GRANT_I) |-> i_valid);
    d_holds_valid: assert property (@(posedge clk) disable iff (!reset)
        (state == GRANT_D) |-> d_valid);
    i_holds_addr: assert property (@(posedge clk) disable iff (!reset)
        (state == GRANT_I && !m_data_ok) |=> $stable(i_addr));
    d_holds_addr: assert property (@(posedge clk) disable iff (!reset)
        (state == GRANT_D && !m_data_ok) |=> $stable(d_addr));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_valid, d_valid;
    logic [AW-1:0] i_addr, d_addr;
    logic [2:0]    d_size;
    logic [SW-1:0] d_strobe;
    logic [DW-1:0] d_wdata;
    logic          i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          m_valid, m_addr_ok, m_data_ok;
    logic [AW-1:0] m_addr;
    logic [2:0]    m_size;
    logic [SW-1:0] m_strobe;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          grant_i, grant_d;

    logic          rsp_dok = 1'b0;
    logic          force_dok = 1'b0;
    int            lat = 2;
    int            rsp_cnt = 0;

    int            n_checks = 0;
    int            n_errors = 0;

    logic [63:0]   iq[$];
    logic [63:0]   dq[$];
    logic [7:0]    grant_log[$];
    int            gaps[$];
    int            idle_run = 0;
    logic          prev_gi = 1'b0, prev_gd = 1'b0;
    logic [SW-1:0] last_d_strobe = '0;
    logic [DW-1:0] last_d_wdata = '0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .grant_i(grant_i), .grant_d(grant_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rdata_of(input logic [63:0] a);
        return a ^ 64'h0000_0000_8000_1234;
    endfunction

    // Memory model: completes a granted request on its lat-th cycle.
    assign m_addr_ok = m_valid;
    assign m_data_ok = rsp_dok | force_dok;

    always @(posedge clk) begin
        #1;
        if ((grant_i | grant_d) && m_valid) begin
            rsp_cnt++;
            rsp_dok = (rsp_cnt == lat);
            m_rdata = rdata_of(m_addr);
        end else begin
            rsp_cnt = 0;
            rsp_dok = 1'b0;
            m_rdata = '0;
        end
    end

    always @(negedge clk) begin
        check("grant_mutex", {63'd0, grant_i & grant_d}, 64'd0);
        check("m_valid_owner", {63'd0, m_valid}, {63'd0, (grant_i & i_valid) | (grant_d & d_valid)});
        if (grant_i) begin
            check("mi_addr", m_addr, i_addr);
            check("mi_size", {61'd0, m_size}, 64'd3);
            check("mi_strobe", {56'd0, m_strobe}, 64'd0);
            check("mi_wdata", m_wdata, 64'd0);
            check("i_addr_ok", {63'd0, i_addr_ok}, {63'd0, m_addr_ok});
            check("d_addr_ok_quiet", {63'd0, d_addr_ok}, 64'd0);
        end else if (grant_d) begin
            check("md_addr", m_addr, d_addr);
            check("md_size", {61'd0, m_size}, {61'd0, d_size});
            check("md_strobe", {56'd0, m_strobe}, {56'd0, d_strobe});
            check("md_wdata", m_wdata, d_wdata);
            check("d_addr_ok", {63'd0, d_addr_ok}, {63'd0, m_addr_ok});
            check("i_addr_ok_quiet", {63'd0, i_addr_ok}, 64'd0);
            last_d_strobe = m_strobe;
            last_d_wdata  = m_wdata;
        end else begin
            check("idle_m_valid", {63'd0, m_valid}, 64'd0);
            check("idle_m_addr", m_addr, 64'd0);
            check("idle_m_wdata", m_wdata, 64'd0);
        end
        if (grant_i && !prev_gi) grant_log.push_back(8'h49);
        if (grant_d && !prev_gd) grant_log.push_back(8'h44);
        prev_gi = grant_i;
        prev_gd = grant_d;
        if (!m_valid) idle_run++;
        if (i_data_ok) begin
            if (iq.size() == 0) check("i_spurious_data_ok", {63'd0, i_data_ok}, 64'd0);
            else check("i_rdata", i_rdata, iq.pop_front());
            gaps.push_back(idle_run);
            idle_run = 0;
        end
        if (d_data_ok) begin
            if (dq.size() == 0) check("d_spurious_data_ok", {63'd0, d_data_ok}, 64'd0);
            else check("d_rdata", d_rdata, dq.pop_front());
        end
    end

    task automatic i_txn(input logic [63:0] addr);
        i_valid = 1'b1;
        i_addr  = addr;
        iq.push_back(rdata_of(addr));
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (i_data_ok) break;
        end
        if (!i_data_ok) check("i_timeout", {63'd0, i_data_ok}, 64'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_addr  = '0;
    endtask

    task automatic d_txn(input logic [63:0] addr, input logic [2:0] size,
                         input logic [SW-1:0] strobe, input logic [DW-1:0] wdata);
        d_valid  = 1'b1;
        d_addr   = addr;
        d_size   = size;
        d_strobe = strobe;
        d_wdata  = wdata;
        dq.push_back(rdata_of(addr));
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (d_data_ok) break;
        end
        if (!d_data_ok) check("d_timeout", {63'd0, d_data_ok}, 64'd1);
        @(posedge clk);
        #1;
        d_valid  = 1'b0;
        d_addr   = '0;
        d_size   = '0;
        d_strobe = '0;
        d_wdata  = '0;
    endtask

    task automatic apply_reset;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        i_valid = 1'b0;
        d_valid = 1'b0;
        #1;
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_grants", {62'd0, grant_i, grant_d}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [7:0] exp_order[6];
    int         n_dok;

    initial begin
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
        m_rdata = '0;

        // Asynchronous reset, checked before any clock edge.
        #1 reset = 1'b0;
        #1;
        check("por_m_valid", {63'd0, m_valid}, 64'd0);
        check("por_grants", {62'd0, grant_i, grant_d}, 64'd0);
        check("por_data_ok", {62'd0, i_data_ok, d_data_ok}, 64'd0);
        check("por_m_addr", m_addr, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Lone fetch: grant next cycle, data on 2nd granted cycle.
        lat = 2;
        i_valid = 1'b1;
        i_addr  = 64'h8000_0000;
        iq.push_back(64'h1234);
        @(negedge clk);
        check("t20_req_cycle_m_valid", {63'd0, m_valid}, 64'd0);
        @(negedge clk);
        check("t20_m_valid", {63'd0, m_valid}, 64'd1);
        check("t20_grant_i", {63'd0, grant_i}, 64'd1);
        @(negedge clk);
        check("t20_i_data_ok", {63'd0, i_data_ok}, 64'd1);
        check("t20_i_rdata", i_rdata, 64'h1234);
        check("t20_d_data_ok", {63'd0, d_data_ok}, 64'd0);
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(negedge clk);
        check("t20_back_idle", {62'd0, grant_i, grant_d}, 64'd0);

        // Simultaneous requests with a clear counter: D first, store payload mirrored.
        apply_reset;
        grant_log.delete();
        fork
            d_txn(64'h1000, 3'b011, 8'hF0, 64'hAABBCCDD_00000000);
            i_txn(64'h2000);
        join
        check("t21_n_grants", 64'(grant_log.size()), 64'd2);
        check("t21_first", {56'd0, grant_log[0]}, 64'h44);
        check("t21_second", {56'd0, grant_log[1]}, 64'h49);
        check("t21_strobe", {56'd0, last_d_strobe}, 64'hF0);
        check("t21_wdata", last_d_wdata, 64'hAABBCCDD_00000000);

        // Continuous contention: I is starved exactly four times, then counter restarts.
        apply_reset;
        lat = 1;
        grant_log.delete();
        fork
            begin
                for (int k = 0; k < 5; k++) d_txn(64'h3000 + 64'(k * 8), 3'b011, 8'h00, 64'd0);
            end
            i_txn(64'h4000);
        join
        exp_order = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49, 8'h44};
        check("t22_n_grants", 64'(grant_log.size()), 64'd6);
        for (int k = 0; k < 6; k++) check($sformatf("t22_order%0d", k), {56'd0, grant_log[k]}, {56'd0, exp_order[k]});

        // Reset in the middle of a D transaction.
        lat = 20;
        @(posedge clk);
        #1;
        d_valid = 1'b1; d_addr = 64'h5000; d_size = 3'b010; d_strobe = 8'h0F; d_wdata = 64'h55;
        repeat (2) @(negedge clk);
        check("t23_grant_d_before", {63'd0, grant_d}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check("t23_m_valid_now", {63'd0, m_valid}, 64'd0);
        check("t23_grant_d_now", {63'd0, grant_d}, 64'd0);
        d_valid = 1'b0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        n_dok = 0;
        repeat (25) begin
            @(negedge clk);
            if (d_data_ok) n_dok++;
        end
        check("t23_no_d_data_ok", 64'(n_dok), 64'd0);

        // Stray m_data_ok in IDLE.
        @(posedge clk);
        #1 force_dok = 1'b1;
        @(negedge clk);
        check("t24_i_data_ok", {63'd0, i_data_ok}, 64'd0);
        check("t24_d_data_ok", {63'd0, d_data_ok}, 64'd0);
        @(posedge clk);
        #1 force_dok = 1'b0;
        @(negedge clk);
        check("t24_still_idle", {62'd0, grant_i, grant_d}, 64'd0);

        // Back-to-back fetches: one IDLE cycle between completions.
        lat = 1;
        @(posedge clk);
        #1;
        gaps.delete();
        i_txn(64'h6000);
        i_txn(64'h6008);
        check("t25_n_done", 64'(gaps.size()), 64'd2);
        check("t25_idle_gap", 64'(gaps[1]), 64'd1);

        repeat (2) @(negedge clk);
        check("end_i_queue_empty", 64'(iq.size()), 64'd0);
        check("end_d_queue_empty", 64'(dq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end
endmodule
